// File: rtl/trng_uart_pkg.sv
// Shared types and register map for the TRNG byte-stream UART transmitter.
package trng_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_DIV_LO = 4'h1;
    localparam logic [3:0] ADDR_DIV_HI = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h3;
    localparam logic [3:0] ADDR_LAST   = 4'h4;

    localparam int unsigned CTRL_EN      = 0;
    localparam int unsigned CTRL_CLR_OVF = 1;
    localparam int unsigned CTRL_FLUSH   = 2;

    localparam int unsigned STAT_FULL  = 3;
    localparam int unsigned STAT_EMPTY = 4;
    localparam int unsigned STAT_BUSY  = 5;
    localparam int unsigned STAT_OVF   = 6;

endpackage

// File: rtl/trng_uart_tx_if.sv
// Byte-stream input, core register bus and PMOD output of the TRNG UART transmitter.
interface trng_uart_tx_if;

    logic [7:0] byte_in;
    logic       byte_valid;
    logic [3:0] address;
    logic       data_write;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic [7:0] uo_out;

    modport master (
        output byte_in, byte_valid, address, data_write, data_in,
        input  data_out, uo_out
    );

    modport slave (
        input  byte_in, byte_valid, address, data_write, data_in,
        output data_out, uo_out
    );

endinterface

// File: rtl/trng_byte_fifo.sv
// Small synchronous byte FIFO; flush has priority over push and pop.
module trng_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [2:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [2:0]       count_q, count_d;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            count_d = count_q + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == 3'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: rtl/trng_uart_tx.sv
// Buffers TRNG bytes and serialises them as 8N1 UART, with a small register window
// for enable, baud divider and status.
module trng_uart_tx
    import trng_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_WIDTH  = 12,
    parameter int unsigned DIV_RESET  = 555
) (
    input  logic          clk,
    input  logic          rst,
    trng_uart_tx_if.slave bus
);

    tx_state_t            state_q, state_d;
    logic [7:0]           shreg_q, shreg_d;
    logic [2:0]           idx_q, idx_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 tx_q, tx_d;
    logic                 en_q, en_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           last_q, last_d;

    logic       pop, push_ok, ovf_evt, flush, clr_ovf, wr_ctrl, busy, cnt_zero;
    logic [7:0] fifo_dout;
    logic       fifo_full, fifo_empty;
    logic [2:0] fifo_count;
    logic [7:0] status;

    trng_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_ok),
        .pop   (pop),
        .flush (flush),
        .din   (bus.byte_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign wr_ctrl  = bus.data_write && (bus.address == ADDR_CTRL);
    assign flush    = wr_ctrl && bus.data_in[CTRL_FLUSH];
    assign clr_ovf  = wr_ctrl && bus.data_in[CTRL_CLR_OVF];
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign push_ok  = bus.byte_valid && !flush && (!fifo_full || pop);
    assign ovf_evt  = bus.byte_valid && !flush && fifo_full && !pop;
    assign busy     = (state_q != IDLE);
    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        en_d   = en_q;
        div_d  = div_q;
        ovf_d  = ovf_q;
        last_d = last_q;
        if (bus.data_write) begin
            case (bus.address)
                ADDR_CTRL:   en_d = bus.data_in[CTRL_EN];
                ADDR_DIV_LO: div_d[7:0] = bus.data_in;
                ADDR_DIV_HI: div_d[DIV_WIDTH-1:8] = bus.data_in[DIV_WIDTH-9:0];
                default: ;
            endcase
        end
        if (clr_ovf) ovf_d = 1'b0;
        if (ovf_evt) ovf_d = 1'b1;
        if (push_ok) last_d = bus.byte_in;
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (en_q && !fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_dout;
                    cnt_d   = div_q;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_zero) begin
                    tx_d    = shreg_q[0];
                    shreg_d = shreg_q >> 1;
                    idx_d   = '0;
                    cnt_d   = div_q;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    cnt_d = div_q;
                    if (idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        tx_d    = shreg_q[0];
                        shreg_d = shreg_q >> 1;
                        idx_d   = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    // Chain straight into the next start bit when more data is waiting.
                    if (en_q && !fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_dout;
                        cnt_d   = div_q;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
            en_q    <= 1'b0;
            div_q   <= DIV_WIDTH'(DIV_RESET);
            ovf_q   <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            div_q   <= div_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        status             = '0;
        status[2:0]        = fifo_count;
        status[STAT_FULL]  = fifo_full;
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_BUSY]  = busy;
        status[STAT_OVF]   = ovf_q;
    end

    always_comb begin
        bus.data_out = '0;
        case (bus.address)
            ADDR_CTRL:   bus.data_out[CTRL_EN] = en_q;
            ADDR_DIV_LO: bus.data_out = div_q[7:0];
            ADDR_DIV_HI: bus.data_out = 8'(div_q >> 8);
            ADDR_STATUS: bus.data_out = status;
            ADDR_LAST:   bus.data_out = last_q;
            default: ;
        endcase
    end

    assign bus.uo_out = {6'b0, busy, tx_q};

endmodule

// File: tb/tb_trng_uart_tx.sv
// Self-checking bench for trng_uart_tx: exact line waveforms for directed frames and a
// sampling UART receiver model for randomized traffic.
module tb_trng_uart_tx;
    import trng_uart_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    trng_uart_tx_if bus_if();

    trng_uart_tx #(
        .FIFO_DEPTH (4),
        .DIV_WIDTH  (12),
        .DIV_RESET  (555)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int         rx_div = 3;
    logic [7:0] rx_q[$];
    int         rx_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [3:0] a, input logic [7:0] d);
        bus_if.address    = a;
        bus_if.data_in    = d;
        bus_if.data_write = 1'b1;
        tick();
        bus_if.data_write = 1'b0;
    endtask

    task automatic reg_read(input logic [3:0] a, output logic [7:0] d);
        bus_if.address = a;
        #1;
        d = bus_if.data_out;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in    = b;
        tick();
        bus_if.byte_valid = 1'b0;
    endtask

    task automatic set_div(input int d);
        logic [11:0] dv;
        dv = 12'(d);
        reg_write(ADDR_DIV_LO, dv[7:0]);
        reg_write(ADDR_DIV_HI, {4'h0, dv[11:8]});
        rx_div = d;
    endtask

    // Bit i of an 8N1 frame: start, eight data bits LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return b[i-1];
    endfunction

    // Receiver model: detects the start bit and samples each bit at its centre.
    initial begin : rx_monitor
        int         d;
        logic [7:0] b;
        logic       good;
        forever begin
            @(posedge clk); #1;
            if (rst === 1'b0 && bus_if.uo_out[0] === 1'b0) begin
                d    = rx_div;
                good = 1'b1;
                repeat (d / 2) begin @(posedge clk); #1; end
                if (bus_if.uo_out[0] !== 1'b0) good = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (d + 1) begin @(posedge clk); #1; end
                    b[i] = bus_if.uo_out[0];
                end
                repeat (d + 1) begin @(posedge clk); #1; end
                if (bus_if.uo_out[0] !== 1'b1) good = 1'b0;
                if (good) rx_q.push_back(b);
                else rx_err++;
                repeat (d - d / 2) begin @(posedge clk); #1; end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic test_reset();
        logic [7:0] rd;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL reset_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL reset_status: got %h want %h", rd, 8'h10); end
        reg_read(ADDR_CTRL, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL reset_ctrl: got %h want %h", rd, 8'h00); end
        reg_read(ADDR_DIV_LO, rd);
        n_cmp++; if (rd !== 8'h2B) begin n_bad++; $display("FAIL reset_div_lo: got %h want %h", rd, 8'h2B); end
        reg_read(ADDR_DIV_HI, rd);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL reset_div_hi: got %h want %h", rd, 8'h02); end
        reg_read(ADDR_LAST, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL reset_last: got %h want %h", rd, 8'h00); end

        set_div(3);
        reg_write(ADDR_CTRL, 8'h01);
        push_byte(8'h80);
        repeat (10) tick();
        n_cmp++; if (bus_if.uo_out !== 8'h02) begin n_bad++; $display("FAIL midframe_pre_reset_uo: got %h want %h", bus_if.uo_out, 8'h02); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL async_reset_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL async_reset_status: got %h want %h", rd, 8'h10); end
        reg_read(ADDR_CTRL, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL async_reset_ctrl: got %h want %h", rd, 8'h00); end
        reg_read(ADDR_DIV_LO, rd);
        n_cmp++; if (rd !== 8'h2B) begin n_bad++; $display("FAIL async_reset_div_lo: got %h want %h", rd, 8'h2B); end
        reg_read(ADDR_DIV_HI, rd);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL async_reset_div_hi: got %h want %h", rd, 8'h02); end
        reg_read(ADDR_LAST, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL async_reset_last: got %h want %h", rd, 8'h00); end
        repeat (2) tick();
        rst = 1'b0;
        repeat (50) tick();
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL post_reset_idle_uo: got %h want %h", bus_if.uo_out, 8'h01); end
    endtask

    task automatic test_regs();
        logic [7:0] rd;
        reg_write(ADDR_CTRL, 8'h07);
        reg_read(ADDR_CTRL, rd);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL ctrl_readback: got %h want %h", rd, 8'h01); end
        reg_write(ADDR_DIV_HI, 8'hFF);
        reg_read(ADDR_DIV_HI, rd);
        n_cmp++; if (rd !== 8'h0F) begin n_bad++; $display("FAIL div_hi_mask: got %h want %h", rd, 8'h0F); end
        reg_write(ADDR_DIV_LO, 8'h5C);
        reg_read(ADDR_DIV_LO, rd);
        n_cmp++; if (rd !== 8'h5C) begin n_bad++; $display("FAIL div_lo_readback: got %h want %h", rd, 8'h5C); end
        reg_write(4'h9, 8'hFF);
        reg_write(4'h3, 8'hFF);
        reg_read(ADDR_DIV_LO, rd);
        n_cmp++; if (rd !== 8'h5C) begin n_bad++; $display("FAIL unlisted_write_ignored: got %h want %h", rd, 8'h5C); end
        reg_read(4'h7, rd);
        n_cmp++; if (rd !== 8'h00) begin n_bad++; $display("FAIL unlisted_read: got %h want %h", rd, 8'h00); end
        reg_write(ADDR_CTRL, 8'h06);
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL regs_status: got %h want %h", rd, 8'h10); end
    endtask

    task automatic test_single_frame();
        logic [7:0] rd;
        reg_write(ADDR_CTRL, 8'h06);
        set_div(3);
        reg_write(ADDR_CTRL, 8'h01);
        push_byte(8'hA5);
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL single_stored_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h01) begin n_bad++; $display("FAIL single_stored_status: got %h want %h", rd, 8'h01); end
        tick();
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h30) begin n_bad++; $display("FAIL single_popped_status: got %h want %h", rd, 8'h30); end
        for (int j = 0; j < 40; j++) begin
            n_cmp++;
            if (bus_if.uo_out !== {6'b0, 1'b1, frame_bit(8'hA5, j / 4)}) begin
                n_bad++;
                $display("FAIL single_wave[%0d]: got %h want %h", j, bus_if.uo_out, {6'b0, 1'b1, frame_bit(8'hA5, j / 4)});
            end
            tick();
        end
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL single_end_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL single_end_status: got %h want %h", rd, 8'h10); end
    endtask

    task automatic test_overflow();
        logic [7:0] rd;
        reg_write(ADDR_CTRL, 8'h06);
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h4C) begin n_bad++; $display("FAIL ovf_status: got %h want %h", rd, 8'h4C); end
        reg_read(ADDR_LAST, rd);
        n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL ovf_last: got %h want %h", rd, 8'h04); end
        reg_write(ADDR_CTRL, 8'h02);
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h0C) begin n_bad++; $display("FAIL ovf_clear_status: got %h want %h", rd, 8'h0C); end
        bus_if.byte_valid = 1'b1;
        bus_if.byte_in    = 8'h33;
        reg_write(ADDR_CTRL, 8'h04);
        bus_if.byte_valid = 1'b0;
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL flush_vs_push_status: got %h want %h", rd, 8'h10); end
        reg_read(ADDR_LAST, rd);
        n_cmp++; if (rd !== 8'h04) begin n_bad++; $display("FAIL flush_vs_push_last: got %h want %h", rd, 8'h04); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] rd;
        logic [7:0] b;
        logic       e;
        reg_write(ADDR_CTRL, 8'h06);
        set_div(1);
        push_byte(8'h00);
        push_byte(8'hFF);
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h02) begin n_bad++; $display("FAIL b2b_queued_status: got %h want %h", rd, 8'h02); end
        reg_write(ADDR_CTRL, 8'h01);
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL b2b_pre_pop_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        tick();
        for (int j = 0; j < 40; j++) begin
            b = (j < 20) ? 8'h00 : 8'hFF;
            e = frame_bit(b, (j % 20) / 2);
            n_cmp++;
            if (bus_if.uo_out !== {6'b0, 1'b1, e}) begin
                n_bad++;
                $display("FAIL b2b_wave[%0d]: got %h want %h", j, bus_if.uo_out, {6'b0, 1'b1, e});
            end
            tick();
        end
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL b2b_end_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL b2b_end_status: got %h want %h", rd, 8'h10); end
    endtask

    task automatic test_mid_frame();
        logic [7:0] rd;
        int         bad_idle;
        reg_write(ADDR_CTRL, 8'h06);
        set_div(3);
        reg_write(ADDR_CTRL, 8'h01);
        push_byte(8'h3C);
        push_byte(8'hAA);
        push_byte(8'h55);
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h22) begin n_bad++; $display("FAIL mid_queued_status: got %h want %h", rd, 8'h22); end
        for (int j = 1; j < 40; j++) begin
            n_cmp++;
            if (bus_if.uo_out !== {6'b0, 1'b1, frame_bit(8'h3C, j / 4)}) begin
                n_bad++;
                $display("FAIL mid_wave[%0d]: got %h want %h", j, bus_if.uo_out, {6'b0, 1'b1, frame_bit(8'h3C, j / 4)});
            end
            if (j == 10) begin
                bus_if.address    = ADDR_CTRL;
                bus_if.data_in    = 8'h04;
                bus_if.data_write = 1'b1;
            end
            tick();
            if (j == 10) begin
                bus_if.data_write = 1'b0;
                reg_read(ADDR_STATUS, rd);
                n_cmp++; if (rd !== 8'h30) begin n_bad++; $display("FAIL mid_flushed_status: got %h want %h", rd, 8'h30); end
            end
        end
        n_cmp++; if (bus_if.uo_out !== 8'h01) begin n_bad++; $display("FAIL mid_end_uo: got %h want %h", bus_if.uo_out, 8'h01); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL mid_end_status: got %h want %h", rd, 8'h10); end
        bad_idle = 0;
        repeat (30) begin
            tick();
            if (bus_if.uo_out !== 8'h01) bad_idle++;
        end
        n_cmp++; if (bad_idle !== 0) begin n_bad++; $display("FAIL mid_stays_idle: got %0d non-idle cycles want 0", bad_idle); end
    endtask

    task automatic test_simultaneous();
        logic [7:0] rd;
        logic [7:0] exp_q[$];
        logic [7:0] b;
        int         waited;
        reg_write(ADDR_CTRL, 8'h06);
        set_div(1);
        reg_write(ADDR_CTRL, 8'h01);
        rx_q.delete();
        rx_err = 0;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            push_byte(b);
        end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h2C) begin n_bad++; $display("FAIL simul_full_status: got %h want %h", rd, 8'h2C); end
        repeat (16) tick();
        exp_q.push_back(8'h5A);
        push_byte(8'h5A);
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h2C) begin n_bad++; $display("FAIL simul_push_pop_status: got %h want %h", rd, 8'h2C); end
        reg_read(ADDR_LAST, rd);
        n_cmp++; if (rd !== 8'h5A) begin n_bad++; $display("FAIL simul_last: got %h want %h", rd, 8'h5A); end
        waited = 0;
        while (!(rx_q.size() >= 6 && bus_if.uo_out[1] === 1'b0) && waited < 200) begin
            tick();
            waited++;
        end
        n_cmp++; if (rx_q.size() !== 6) begin n_bad++; $display("FAIL simul_rx_count: got %0d want %0d", rx_q.size(), 6); end
        for (int i = 0; i < 6; i++) begin
            if (i < rx_q.size()) begin
                n_cmp++;
                if (rx_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL simul_rx_byte[%0d]: got %h want %h", i, rx_q[i], exp_q[i]); end
            end
        end
        n_cmp++; if (rx_err !== 0) begin n_bad++; $display("FAIL simul_framing: got %0d errors want 0", rx_err); end
        reg_read(ADDR_STATUS, rd);
        n_cmp++; if (rd !== 8'h10) begin n_bad++; $display("FAIL simul_end_status: got %h want %h", rd, 8'h10); end
    endtask

    task automatic test_random();
        logic [7:0] rd;
        logic [7:0] mq[$];
        logic [7:0] mlast;
        logic [7:0] exp_st;
        logic [7:0] b;
        logic       movf;
        int         n, d, waited, limit;
        for (int it = 0; it < 6; it++) begin
            reg_write(ADDR_CTRL, 8'h06);
            mq.delete();
            movf  = 1'b0;
            mlast = 8'h00;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                push_byte(b);
                if (mq.size() < DEPTH) begin
                    mq.push_back(b);
                    mlast = b;
                end else begin
                    movf = 1'b1;
                end
                exp_st = {1'b0, movf, 1'b0, (mq.size() == 0), (mq.size() == DEPTH), 3'(mq.size())};
                reg_read(ADDR_STATUS, rd);
                n_cmp++; if (rd !== exp_st) begin n_bad++; $display("FAIL rand%0d_fill_status[%0d]: got %h want %h", it, i, rd, exp_st); end
                repeat ($urandom_range(0, 2)) tick();
            end
            reg_read(ADDR_LAST, rd);
            n_cmp++; if (rd !== mlast) begin n_bad++; $display("FAIL rand%0d_last: got %h want %h", it, rd, mlast); end
            d = (it == 0) ? 0 : int'($urandom_range(0, 4));
            set_div(d);
            rx_q.delete();
            rx_err = 0;
            reg_write(ADDR_CTRL, 8'h01);
            limit  = mq.size() * 10 * (d + 1) + 30;
            waited = 0;
            while (!(rx_q.size() >= mq.size() && bus_if.uo_out[1] === 1'b0) && waited < limit) begin
                tick();
                waited++;
            end
            n_cmp++; if (rx_q.size() !== mq.size()) begin n_bad++; $display("FAIL rand%0d_rx_count: got %0d want %0d (div %0d)", it, rx_q.size(), mq.size(), d); end
            for (int i = 0; i < mq.size(); i++) begin
                if (i < rx_q.size()) begin
                    n_cmp++;
                    if (rx_q[i] !== mq[i]) begin n_bad++; $display("FAIL rand%0d_rx_byte[%0d]: got %h want %h", it, i, rx_q[i], mq[i]); end
                end
            end
            n_cmp++; if (rx_err !== 0) begin n_bad++; $display("FAIL rand%0d_framing: got %0d errors want 0", it, rx_err); end
            exp_st = movf ? 8'h50 : 8'h10;
            reg_read(ADDR_STATUS, rd);
            n_cmp++; if (rd !== exp_st) begin n_bad++; $display("FAIL rand%0d_end_status: got %h want %h", it, rd, exp_st); end
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.byte_in    = 8'h00;
        bus_if.byte_valid = 1'b0;
        bus_if.address    = 4'h0;
        bus_if.data_write = 1'b0;
        bus_if.data_in    = 8'h00;
        test_reset();
        test_regs();
        test_single_frame();
        test_overflow();
        test_back_to_back();
        test_mid_frame();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trng_uart_tx.md
# trng_uart_tx

Byte-stream consumer for the ring-oscillator TRNG peripheral: it accepts each packed random byte on a single-cycle strobe, buffers it in a small FIFO and serialises it as 8N1 UART on the output PMOD. It also exposes a register window to the TinyQV core for control, baud setting and status. It sits directly downstream of the TRNG byte packager, inside the same user-peripheral slot.

## Interface
Parameters:
- FIFO_DEPTH, 4: byte FIFO entries. Legal range 2..7, because the STATUS count field is 3 bits.
- DIV_WIDTH, 12: width of the baud divider.
- DIV_RESET, 555: reset divider. Bit period is DIV+1 clk cycles, so 556 cycles gives ≈115.1 kbaud at 64 MHz.

Ports:
- clk  in  1  peripheral clock, 64 MHz nominal.
- rst  in  1  reset; asynchronous, active-high.
- byte_in  in  8  random byte from the TRNG packager.
- byte_valid  in  1  single-cycle strobe; byte_in is valid while it is high.
- address  in  4  register address.
- data_write  in  1  core write strobe.
- data_in  in  8  core write data.
- data_out  out  8  register read data; combinational from address.
- uo_out  out  8  output PMOD:
  - [0] TX line, idle high.
  - [1] busy.
  - [7:2] are 0.

## Operation
Registers (unlisted addresses read 0x00; writes to them are ignored):
- 0x0 CTRL
  - bit0 EN: read/write, reset 0.
  - bit1 CLR_OVF: write-1 clears the sticky overflow flag; reads 0.
  - bit2 FLUSH: write-1 empties the FIFO; reads 0.
- 0x1 DIV_LO: DIV[7:0].
- 0x2 DIV_HI: DIV[11:8] in bits [3:0]; bits [7:4] read 0.
- 0x3 STATUS (read-only):
  - [2:0] count.
  - [3] full.
  - [4] empty.
  - [5] busy.
  - [6] ovf, sticky.
  - [7] 0.
- 0x4 LAST: last byte accepted into the FIFO; reset 0x00.

FIFO:
- Push on byte_valid when not full.
- byte_valid while full: the byte is dropped, ovf is set, count is unchanged.
- Push and pop in the same cycle while full: the push is accepted and count is unchanged.
- There is no empty-bypass. A byte pushed into an empty FIFO is popped on a later cycle.
- FLUSH in the same cycle as byte_valid: the flush wins, the byte is dropped, and ovf is not set.

Transmit FSM (states IDLE, START, DATA, STOP):
- IDLE: if EN=1 and FIFO non-empty, pop the FIFO, load the shift register, go to START, set busy.
- START drives 0; DATA drives bits LSB-first; STOP drives 1. Each bit lasts DIV+1 cycles, timed by a down-counter reloaded at each bit boundary.
- DATA: a 3-bit index counts 8 bits, then the FSM goes to STOP.
- End of STOP:
  - If EN=1 and FIFO non-empty, pop and go directly to START, with no idle bit between frames.
  - Otherwise go to IDLE and clear busy.
- Clearing EN mid-frame: the current frame completes; no further pops.
- FLUSH mid-frame: the FIFO empties; the current frame completes.
- A DIV write takes effect at the next bit-boundary reload.
- DIV=0 is legal and gives a bit period of 1 cycle.
- busy is 1 in every state except IDLE.

## Timing
- Reset values:
  - uo_out = 0x01; data_out as decoded, so STATUS reads 0x10.
  - FSM in IDLE; FIFO empty; EN=0; DIV=DIV_RESET; ovf=0; LAST=0x00.
- Reset is asynchronous. Asserting it mid-frame forces TX high at once, aborts the frame and empties the FIFO.
- Latency from byte_valid sampled at edge k (EN=1, IDLE, FIFO empty):
  - The byte is stored at edge k, and count=1 is visible after k.
  - The FSM pops at edge k+1, and TX goes low after edge k+1 (registered output).
- A frame lasts 10·(DIV+1) cycles.
- busy falls on the same edge on which TX completes its stop bit and the FSM enters IDLE.
- Register writes take effect on the edge where data_write is sampled. Status reflects state after that edge.

## Structure
- Package trng_uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, STOP);
  - the register address localparams ADDR_CTRL, ADDR_DIV_LO, ADDR_DIV_HI, ADDR_STATUS, ADDR_LAST;
  - the CTRL and STATUS bit-index constants.
- One sub-module, trng_byte_fifo: a synchronous FIFO with push, pop, flush, full, empty and count, parameterised by depth.
- FSM, divider, shift register and register decode stay in the top module.

## Test plan
- Reset: assert rst mid-operation → uo_out=0x01 immediately; STATUS=0x10, CTRL=0x00, DIV_LO=0x2B, DIV_HI=0x02.
- Single frame: DIV=3, EN=1, byte 0xA5 strobed at cycle 0 → TX low over cycles 2–5, then 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; busy high for exactly 40 cycles.
- Overflow: EN=0, strobe 5 bytes 0x01..0x05 → STATUS=0x4C, LAST=0x04; write CTRL=0x02 → STATUS=0x0C.
- Back-to-back: DIV=1, push 0x00 and 0xFF, EN=1 → 40 contiguous cycles of frames with stop bit followed immediately by start bit; busy never drops between frames; FIFO empty at the end.
- Mid-frame control: during DATA, write CTRL=0x04 (EN=0 with FLUSH) while 2 bytes are queued → current frame finishes intact, count=0, TX stays high, STATUS=0x10.
- Simultaneous push and pop: FIFO full, a pop at end of STOP coincides with byte_valid=0x5A → count stays 4, ovf stays 0, 0x5A transmitted last.
